// File: rtl/bk_sd_streamer.sv
// Backup-RAM <-> SD image streamer.
// Loads a save image sector by sector into backup RAM when an image is
// mounted, and writes backup RAM back to the image on an OSD save strobe.
// Sector index comes from sd_lba[7:0]; word index from sd_buff_addr.
module bk_sd_streamer #(
  parameter int BK_AW = 17
) (
  input  logic             clk_sys,
  input  logic             reset,

  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic [63:0]      img_size,

  input  logic             bk_save_req,
  input  logic             has_save,
  input  logic             cart_ready,
  input  logic [7:0]       ram_mask_file,

  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,

  input  logic [7:0]       sd_buff_addr,
  input  logic [15:0]      sd_buff_dout,
  input  logic             sd_buff_wr,
  output logic [15:0]      sd_buff_din,

  output logic [BK_AW-1:0] bk_addr,
  output logic             bk_wr,
  output logic [15:0]      bk_data,
  input  logic [15:0]      bk_q,

  output logic             bk_busy,
  output logic             bk_loading
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_REQ  = 3'd1;
  localparam logic [2:0] S_LOAD_XFER = 3'd2;
  localparam logic [2:0] S_SAVE_REQ  = 3'd3;
  localparam logic [2:0] S_SAVE_XFER = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;

  logic [2:0] state;
  logic [7:0] lba;
  logic       op_load;
  logic       rd_q;
  logic       wr_q;

  logic       mount_prev;
  logic       save_prev;
  logic       mounted;
  logic       load_pend;
  logic       save_pend;

  logic       mount_edge;
  logic       save_edge;
  logic       mount_ok;
  logic       mounted_now;
  logic       load_req;
  logic       save_req;
  logic       last_sector;
  logic       finish_load;
  logic       finish_save;

  // Request qualification; a mount in the same cycle as a save strobe
  // already counts as mounted so both can be queued together.
  always_comb begin
    mount_edge  = img_mounted & ~mount_prev;
    save_edge   = bk_save_req & ~save_prev;
    mount_ok    = (img_size != 64'd0);
    mounted_now = mount_edge ? mount_ok : mounted;
    load_req    = mount_edge & mount_ok;
    save_req    = save_edge & has_save & mounted_now & ~img_readonly;
    last_sector = (lba == ram_mask_file);
    finish_load = (state == S_NEXT) & last_sector & op_load;
    finish_save = (state == S_NEXT) & last_sector & ~op_load;
  end

  // Edge history, mounted flag and pending requests; a new request wins
  // over the completion clear so back-to-back requests are never lost.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mount_prev <= 1'b0;
      save_prev  <= 1'b0;
      mounted    <= 1'b0;
      load_pend  <= 1'b0;
      save_pend  <= 1'b0;
    end else begin
      mount_prev <= img_mounted;
      save_prev  <= bk_save_req;
      if (mount_edge) mounted <= mount_ok;
      if (finish_load) load_pend <= 1'b0;
      if (finish_save) save_pend <= 1'b0;
      if (load_req) load_pend <= 1'b1;
      if (save_req) save_pend <= 1'b1;
    end
  end

  // Transfer sequencer: request handshake, wait for the host to finish the
  // sector, then either advance to the next sector or return to idle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= S_IDLE;
      lba     <= 8'd0;
      op_load <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_pend) begin
            state   <= S_LOAD_REQ;
            lba     <= 8'd0;
            op_load <= 1'b1;
            rd_q    <= 1'b1;
          end else if (save_pend && cart_ready) begin
            state   <= S_SAVE_REQ;
            lba     <= 8'd0;
            op_load <= 1'b0;
            wr_q    <= 1'b1;
          end
        end
        S_LOAD_REQ: begin
          if (sd_ack) begin
            rd_q  <= 1'b0;
            state <= S_LOAD_XFER;
          end
        end
        S_SAVE_REQ: begin
          if (sd_ack) begin
            wr_q  <= 1'b0;
            state <= S_SAVE_XFER;
          end
        end
        S_LOAD_XFER, S_SAVE_XFER: begin
          if (!sd_ack) state <= S_NEXT;
        end
        S_NEXT: begin
          if (last_sector) begin
            state <= S_IDLE;
          end else begin
            lba <= lba + 8'd1;
            if (op_load) begin
              state <= S_LOAD_REQ;
              rd_q  <= 1'b1;
            end else begin
              state <= S_SAVE_REQ;
              wr_q  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output decode; RAM address and data pass straight through from the
  // SD buffer port so the RAM sees each word in the cycle it is presented.
  always_comb begin
    sd_lba      = {24'd0, lba};
    sd_rd       = rd_q;
    sd_wr       = wr_q;
    bk_addr     = BK_AW'({lba, sd_buff_addr});
    bk_wr       = (state == S_LOAD_XFER) & sd_buff_wr & sd_ack;
    bk_data     = sd_buff_dout;
    sd_buff_din = bk_q;
    bk_busy     = (state != S_IDLE);
    bk_loading  = (state == S_LOAD_REQ) | (state == S_LOAD_XFER) |
                  ((state == S_NEXT) & op_load);
  end

endmodule

// File: doc/bk_sd_streamer.md
BK_SD_STREAMER -- requirements
Module: bk_sd_streamer

Interface
REQ-001 SHALL have parameter BK_AW, default 17, the backup-RAM word-address width driven on bk_addr.
REQ-002 SHALL have port clk_sys, input, 1, the only clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports img_mounted (in, 1, mount pulse), img_readonly (in, 1) and img_size (in, 64, save image bytes).
REQ-005 SHALL have ports bk_save_req (in, 1, OSD save strobe), has_save (in, 1), cart_ready (in, 1) and ram_mask_file (in, 8, last sector index).
REQ-006 SHALL have ports sd_lba (out, 32), sd_rd (out, 1), sd_wr (out, 1) and sd_ack (in, 1).
REQ-007 SHALL have ports sd_buff_addr (in, 8, word index in a 512-byte sector), sd_buff_dout (in, 16), sd_buff_wr (in, 1) and sd_buff_din (out, 16).
REQ-008 SHALL have ports bk_addr (out, BK_AW), bk_wr (out, 1), bk_data (out, 16) and bk_q (in, 16, one-cycle registered read data).
REQ-009 SHALL have ports bk_busy (out, 1, transfer in progress) and bk_loading (out, 1, load in progress; holds the core in reset).

Function
REQ-010 SHALL implement states IDLE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER and NEXT.
REQ-011 SHALL detect rising edges of img_mounted and bk_save_req using registered previous values.
REQ-012 SHALL treat the mount edge with img_size != 0 as a load request; img_size == 0 SHALL NOT start a load.
REQ-013 SHALL treat a bk_save_req edge as a save request only if has_save=1, an image is mounted (img_size != 0 latched at mount) and img_readonly=0.
REQ-014 SHALL latch each request into a pending flag; IDLE SHALL service pending load before pending save when both are set in the same cycle.
REQ-015 SHALL also require cart_ready=1 to leave IDLE for save; a load SHALL NOT depend on cart_ready.
REQ-016 SHALL set sd_lba=0 on entry from IDLE.
REQ-017 LOAD_REQ/SAVE_REQ SHALL hold sd_rd/sd_wr high until sd_ack=1, then drop it the next cycle and enter the XFER state.
REQ-018 XFER states SHALL wait for sd_ack=0, then enter NEXT.
REQ-019 NEXT: if sd_lba[7:0]==ram_mask_file, SHALL go to IDLE and clear the serviced pending flag; else SHALL increment sd_lba by 1 and return to the same REQ state.
REQ-020 sd_lba[31:8] SHALL always be 0.
REQ-021 bk_addr SHALL equal {0, sd_lba[7:0], sd_buff_addr}, zero-extended to BK_AW, combinationally.
REQ-022 bk_wr SHALL equal sd_buff_wr & sd_ack while in LOAD_XFER, else 0; bk_data SHALL equal sd_buff_dout.
REQ-023 sd_buff_din SHALL equal bk_q (read latency one cycle, matching the SD buffer protocol).
REQ-024 bk_busy SHALL be 1 in every state except IDLE; bk_loading SHALL be 1 in LOAD_REQ, LOAD_XFER, and NEXT when reached from a load.
REQ-025 A save edge arriving while busy SHALL set save pending (serviced afterwards); a mount edge while busy SHALL abort nothing and set load pending.
REQ-026 sd_rd and sd_wr SHALL never be high simultaneously.

Reset
REQ-027 Reset SHALL force IDLE, sd_lba=0, sd_rd=0, sd_wr=0, bk_wr=0, bk_busy=0, bk_loading=0, clear both pending flags and edge registers, and clear the mounted flag.
REQ-028 Reset asserted mid-transfer SHALL take effect the next edge, with no further bk_wr pulses.

Verification
REQ-029 Mount with img_size=8192 and ram_mask_file=0x0F -> 16 sd_rd handshakes, lba 0..15; the word at sd_buff_addr=0x05 of lba 3 is written to bk_addr=0x0305; bk_loading then drops.
REQ-030 Save with has_save=1, readonly=0, cart_ready=1 and ram_mask_file=0x03 -> 4 sd_wr handshakes, lba 0..3; sd_buff_din tracks bk_q.
REQ-031 Save edge with img_readonly=1, or with has_save=0 -> no sd_wr, bk_busy stays 0.
REQ-032 Mount edge and save edge in the same cycle -> full load first, then save starts without a new strobe.
REQ-033 Reset asserted during lba 2 of a load -> next cycle sd_rd=0 and IDLE; no bk_wr afterwards.
REQ-034 ram_mask_file=0xFF -> 256 sectors; final bk_addr=0xFFFF and sd_lba never exceeds 0xFF.
